// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory boot loader.
package imem_loader_pkg;

    localparam int unsigned LEN_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = WORD_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles consecutive bytes into little-endian words; word_valid_c flags
// the strobe that completes a word, with word_c carrying the finished word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              strobe,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_valid_c
);

    localparam int unsigned LANE_W  = $clog2(WORD_BYTES);
    localparam int unsigned SHIFT_W = WORD_W - 8;

    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;

    // New byte enters at the top so the first byte ends up in bits [7:0].
    assign word_c       = {byte_in, shift_q};
    assign word_valid_c = strobe && (lane_q == LANE_W'(WORD_BYTES - 1));

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clear) begin
            lane_d  = '0;
            shift_d = '0;
        end else if (strobe) begin
            lane_d  = lane_q + LANE_W'(1);
            shift_d = word_c[WORD_W-1:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame and
// writes the payload words to instruction memory, holding the CPU until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned INS_ADDR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned W_CNT     = INS_ADDR + 1;
    localparam logic [31:0] MAX_WORDS = 32'(1) << INS_ADDR;

    state_e             state_q, state_d;
    logic [W_CNT-1:0]   w_q, w_d;
    logic [W_CNT-1:0]   len_q, len_d;
    logic [7:0]         csum_q, csum_d;
    logic               rx_ready_q, rx_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               rearm;
    logic               pk_strobe;
    logic [WORD_W-1:0]  pk_word_c;
    logic               pk_valid_c;

    assign accept    = rx_valid && rx_ready_q;
    assign rearm     = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign pk_strobe = accept && (state_q == LEN || state_q == DATA);

    // Length bytes and payload bytes share the same little-endian packer.
    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (rearm),
        .strobe       (pk_strobe),
        .byte_in      (rx_data),
        .word_c       (pk_word_c),
        .word_valid_c (pk_valid_c)
    );

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        len_d     = len_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = LEN;
                    w_d     = '0;
                    len_d   = '0;
                    csum_d  = '0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LEN: begin
                if (pk_valid_c) begin
                    if (pk_word_c > MAX_WORDS) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (pk_word_c == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                        len_d   = pk_word_c[W_CNT-1:0];
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                end
                if (pk_valid_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = 32'({w_q, 2'b00});
                    wr_data_d = pk_word_c;
                    w_d       = w_q + W_CNT'(1);
                    if (w_q + W_CNT'(1) == len_q) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rx_ready_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            rx_ready_q <= rx_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_hold  = hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with INS_ADDR=4; writes are captured by a
// monitor and compared against hand-computed frames.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    logic [7:0] good_frame [0:11] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                      8'h13, 8'h05, 8'h10, 8'h00,
                                      8'h93, 8'h05, 8'h20, 8'h00};

    imem_loader #(.INS_ADDR(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte after `gap` idle cycles and returns after the consuming edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t == 20) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic idle_rx();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_good(input logic [7:0] csum, input int maxgap);
        for (int i = 0; i < 12; i++) begin
            send_byte(good_frame[i], (maxgap == 0) ? 0 : int'($urandom_range(1, maxgap)));
        end
        send_byte(csum, (maxgap == 0) ? 0 : int'($urandom_range(1, maxgap)));
        idle_rx();
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_count"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() >= 2) begin
            check({tag, "_addr0"}, wa_q[0], 32'h0000_0000);
            check({tag, "_data0"}, wd_q[0], 32'h0010_0513);
            check({tag, "_addr1"}, wa_q[1], 32'h0000_0004);
            check({tag, "_data1"}, wd_q[1], 32'h0020_0593);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_rx_ready", 32'(rx_ready), 32'd0);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd1);

        // Good frame, back-to-back bytes
        pulse_start();
        check("armed_rx_ready", 32'(rx_ready), 32'd1);
        send_good(8'hB0, 0);
        check("good_done", 32'(load_done), 32'd1);
        check("good_hold", 32'(cpu_hold), 32'd0);
        check("good_rx_ready", 32'(rx_ready), 32'd0);
        check("good_err", 32'(load_err), 32'd0);
        check_two_writes("good");
        repeat (3) @(negedge clk);
        check("good_done_sticky", 32'(load_done), 32'd1);

        // Bad checksum
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        check("restart_done_clr", 32'(load_done), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);
        send_good(8'hB1, 0);
        check("bad_err", 32'(load_err), 32'd1);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        check("bad_done", 32'(load_done), 32'd0);
        check("bad_rx_ready", 32'(rx_ready), 32'd0);
        check_two_writes("bad");

        // Zero length
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        check("zero_err_clr", 32'(load_err), 32'd0);
        for (int i = 0; i < 5; i++) send_byte(8'h00, 0);
        idle_rx();
        repeat (2) @(negedge clk);
        check("zero_writes", 32'(wa_q.size()), 32'd0);
        check("zero_done", 32'(load_done), 32'd1);
        check("zero_hold", 32'(cpu_hold), 32'd0);

        // Oversize length (17 > 16 words)
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        idle_rx();
        check("over_rx_ready", 32'(rx_ready), 32'd0);
        check("over_err", 32'(load_err), 32'd1);
        check("over_hold", 32'(cpu_hold), 32'd1);
        repeat (3) @(negedge clk);
        check("over_writes", 32'(wa_q.size()), 32'd0);
        pulse_start();
        send_good(8'hB0, 0);
        check("over_retry_done", 32'(load_done), 32'd1);
        check("over_retry_err", 32'(load_err), 32'd0);
        check_two_writes("over_retry");

        // Reset mid-word
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(good_frame[i], 0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rx_ready", 32'(rx_ready), 32'd0);
        check("mid_wr_en", 32'(wr_en), 32'd0);
        check("mid_wr_addr", wr_addr, 32'd0);
        check("mid_wr_data", wr_data, 32'd0);
        check("mid_hold", 32'(cpu_hold), 32'd1);
        check("mid_done", 32'(load_done), 32'd0);
        check("mid_err", 32'(load_err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_writes", 32'(wa_q.size()), 32'd0);
        check("mid_idle_ready", 32'(rx_ready), 32'd0);

        // Good frame with random rx_valid gaps
        pulse_start();
        send_good(8'hB0, 3);
        check("gap_done", 32'(load_done), 32'd1);
        check("gap_hold", 32'(cpu_hold), 32'd0);
        check_two_writes("gap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
